// File: rtl/mem_responder.sv
// Memory-side load/store responder with programmable wait states and an internal word RAM.
// Optional build macro MEM_RESPONDER_ALIGN_CHECK_EN turns misaligned accesses into faults.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         WORDS     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

  state_t                  state_r, next_s;
  logic [3:0]              cnt_r;
  logic                    we_r;
  logic [2:0]              f3_r;
  logic [31:0]             addr_r, wdata_r;
  logic [31:0]             mem_r [WORDS];

  logic                    handshake_s, commit_s;
  logic                    cur_we_s;
  logic [2:0]              cur_f3_s;
  logic [31:0]             cur_addr_s, cur_wdata_s;
  logic [ADDR_WIDTH-1:0]   idx_s;
  logic [1:0]              off_s, eff_off_s;
  logic [31:0]             word_s, shifted_s, load_s, wmerge_s, rdata_s;
  logic [3:0]              be_s;
  logic                    f3_bad_s, range_bad_s, align_bad_s, err_s;

  assign req_ready   = (state_r == ST_IDLE) & ~rst;
  assign handshake_s = req_valid & req_ready;
  assign commit_s    = (next_s == ST_RESP);

  // With zero wait states the commit edge is the accept edge, so use live request fields
  assign cur_we_s    = (state_r == ST_IDLE) ? req_we     : we_r;
  assign cur_f3_s    = (state_r == ST_IDLE) ? req_funct3 : f3_r;
  assign cur_addr_s  = (state_r == ST_IDLE) ? req_addr   : addr_r;
  assign cur_wdata_s = (state_r == ST_IDLE) ? req_wdata  : wdata_r;
  assign idx_s       = cur_addr_s[ADDR_WIDTH+1:2];
  assign off_s       = cur_addr_s[1:0];
  assign word_s      = mem_r[idx_s];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_s;
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) next_s = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        else             next_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_r == WAIT_LAST) next_s = ST_RESP;
        else                    next_s = ST_WAIT;
      end
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Wait counter and request capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      f3_r    <= 3'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else begin
      if (state_r == ST_WAIT && next_s == ST_WAIT) cnt_r <= cnt_r + 4'd1;
      else                                         cnt_r <= 4'd0;
      if (handshake_s) begin
        we_r    <= req_we;
        f3_r    <= req_funct3;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

  // Response datapath: fault detection, load extension and store lane merge
  always_comb begin
    range_bad_s = |cur_addr_s[31:ADDR_WIDTH+2];
    if (cur_we_s) f3_bad_s = (cur_f3_s != 3'b000) && (cur_f3_s != 3'b001) && (cur_f3_s != 3'b010);
    else          f3_bad_s = (cur_f3_s == 3'b011) || (cur_f3_s == 3'b110) || (cur_f3_s == 3'b111);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    align_bad_s = ((cur_f3_s[1:0] == 2'b01) && off_s[0]) ||
                  ((cur_f3_s[1:0] == 2'b10) && (off_s != 2'b00));
`else
    align_bad_s = 1'b0;
`endif
    err_s = f3_bad_s | range_bad_s | align_bad_s;

    case (cur_f3_s[1:0])
      2'b00:   eff_off_s = off_s;
      2'b01:   eff_off_s = {off_s[1], 1'b0};
      default: eff_off_s = 2'b00;
    endcase
    shifted_s = word_s >> {eff_off_s, 3'b000};

    case (cur_f3_s)
      3'b000:  load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b010:  load_s = word_s;
      3'b100:  load_s = {24'd0, shifted_s[7:0]};
      3'b101:  load_s = {16'd0, shifted_s[15:0]};
      default: load_s = 32'd0;
    endcase

    case (cur_f3_s[1:0])
      2'b00: begin
        be_s     = 4'b0001 << eff_off_s;
        wmerge_s = {4{cur_wdata_s[7:0]}};
      end
      2'b01: begin
        be_s     = eff_off_s[1] ? 4'b1100 : 4'b0011;
        wmerge_s = {2{cur_wdata_s[15:0]}};
      end
      default: begin
        be_s     = 4'b1111;
        wmerge_s = cur_wdata_s;
      end
    endcase

    if (err_s || cur_we_s) rdata_s = 32'd0;
    else                   rdata_s = load_s;
  end

  // Registered response outputs; data and error hold between responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= commit_s;
      if (commit_s) begin
        rsp_rdata <= rdata_s;
        rsp_err   <= err_s;
      end else begin
        rsp_rdata <= rsp_rdata;
        rsp_err   <= rsp_err;
      end
    end
  end

  // RAM write port, byte-lane masked; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (commit_s && cur_we_s && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) mem_r[idx_s][i*8 +: 8] <= wmerge_s[i*8 +: 8];
      end
    end
  end
endmodule
